// File: rtl/trade_report_framer.sv
// trade_report_framer: queues approved trades in a small FIFO and serialises each one
// as a framed byte stream (SOF, price, qty, buy_id, sell_id[, checksum]) into a UART.
// Build option: define TRADE_REPORT_CHECKSUM_EN to append an XOR checksum byte.
module trade_report_framer #(
  parameter int unsigned DEPTH = 4,
  parameter logic [7:0]  SOF   = 8'hA5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TRADE_APPROVED,
  input  logic [7:0] APPR_PRICE,
  input  logic [7:0] APPR_QTY,
  input  logic [7:0] APPR_BUY_ID,
  input  logic [7:0] APPR_SELL_ID,
  input  logic       TX_BUSY,
  output logic [7:0] TX_DATA,
  output logic       TX_START,
  output logic       FIFO_FULL,
  output logic       FRAME_ACTIVE,
  output logic [7:0] DROP_COUNT
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = 3;
  localparam int unsigned ENT_W = 32;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
`ifdef TRADE_REPORT_CHECKSUM_EN
  localparam logic [IDX_W-1:0] LAST_IDX = 3'd5;
`else
  localparam logic [IDX_W-1:0] LAST_IDX = 3'd4;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_HOLD = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [ENT_W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENT_W-1:0]   frame_q, frame_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               fifo_full_q, fifo_full_d;
  logic               frame_active_q, frame_active_d;
  logic [7:0]         drop_count_q, drop_count_d;
  logic               push, drop, pop;

  // Byte of the frame at position idx; entry layout is {price, qty, buy_id, sell_id}.
  function automatic logic [7:0] frame_byte(input logic [ENT_W-1:0] f,
                                            input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = SOF;
      3'd1:    b = f[31:24];
      3'd2:    b = f[23:16];
      3'd3:    b = f[15:8];
      3'd4:    b = f[7:0];
`ifdef TRADE_REPORT_CHECKSUM_EN
      3'd5:    b = f[31:24] ^ f[23:16] ^ f[15:8] ^ f[7:0];
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Next-state logic for FIFO, framing FSM and registered outputs.
  always_comb begin
    state_d        = state_q;
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    frame_d        = frame_q;
    idx_d          = idx_q;
    tx_data_d      = tx_data_q;
    tx_start_d     = 1'b0;
    frame_active_d = frame_active_q;
    drop_count_d   = drop_count_q;

    // Fullness uses the pre-edge count, so a same-cycle pop never frees a slot.
    push = TRADE_APPROVED && (count_q != FULL_CNT);
    drop = TRADE_APPROVED && (count_q == FULL_CNT);
    pop  = (state_q == S_LOAD);

    if (push) begin
      mem_d[wr_ptr_q] = {APPR_PRICE, APPR_QTY, APPR_BUY_ID, APPR_SELL_ID};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (drop && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    fifo_full_d = (count_d == FULL_CNT);

    // TX_START/TX_DATA are prepared one cycle early so they are high in SEND.
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_LOAD;
      end
      S_LOAD: begin
        frame_d        = mem_q[rd_ptr_q];
        idx_d          = '0;
        frame_active_d = 1'b1;
        tx_start_d     = 1'b1;
        tx_data_d      = frame_byte(mem_q[rd_ptr_q], 3'd0);
        state_d        = S_SEND;
      end
      S_SEND: state_d = S_HOLD;
      S_HOLD: state_d = S_WAIT;
      S_WAIT: begin
        if (!TX_BUSY) begin
          if (idx_q == LAST_IDX) begin
            frame_active_d = 1'b0;
            state_d        = S_IDLE;
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            tx_start_d = 1'b1;
            tx_data_d  = frame_byte(frame_q, idx_q + IDX_W'(1));
            state_d    = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      frame_q        <= '0;
      idx_q          <= '0;
      tx_data_q      <= 8'h00;
      tx_start_q     <= 1'b0;
      fifo_full_q    <= 1'b0;
      frame_active_q <= 1'b0;
      drop_count_q   <= 8'h00;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      frame_q        <= frame_d;
      idx_q          <= idx_d;
      tx_data_q      <= tx_data_d;
      tx_start_q     <= tx_start_d;
      fifo_full_q    <= fifo_full_d;
      frame_active_q <= frame_active_d;
      drop_count_q   <= drop_count_d;
    end
  end

  // FIFO storage; contents are don't-care while count is zero.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign TX_DATA      = tx_data_q;
  assign TX_START     = tx_start_q;
  assign FIFO_FULL    = fifo_full_q;
  assign FRAME_ACTIVE = frame_active_q;
  assign DROP_COUNT   = drop_count_q;

endmodule

// File: tb/tb_trade_report_framer.sv
// Self-checking bench for trade_report_framer: table of single trades plus
// hand-written overflow, saturation, UART back-pressure and reset sequences.
module tb_trade_report_framer;

`ifdef TRADE_REPORT_CHECKSUM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif

  typedef struct {
    logic [7:0] price;
    logic [7:0] qty;
    logic [7:0] buy;
    logic [7:0] sell;
    logic [7:0] ck;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } start_t;

  logic       clk;
  logic       RESET;
  logic       TRADE_APPROVED;
  logic [7:0] APPR_PRICE, APPR_QTY, APPR_BUY_ID, APPR_SELL_ID;
  logic       TX_BUSY;
  logic [7:0] TX_DATA;
  logic       TX_START;
  logic       FIFO_FULL;
  logic       FRAME_ACTIVE;
  logic [7:0] DROP_COUNT;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   app_cyc = 0;
  int   busy_cnt = 0;
  logic busy_force = 1'b0;
  logic uart_en    = 1'b0;
  int   b2b_err    = 0;
  int   stable_err = 0;
  logic prev_start = 1'b0;
  logic [7:0] last_data = 8'h00;
  start_t starts[$];
  vec_t   vecs[5];

  trade_report_framer #(.DEPTH(4), .SOF(8'hA5)) dut (
    .CLK           (clk),
    .RESET         (RESET),
    .TRADE_APPROVED(TRADE_APPROVED),
    .APPR_PRICE    (APPR_PRICE),
    .APPR_QTY      (APPR_QTY),
    .APPR_BUY_ID   (APPR_BUY_ID),
    .APPR_SELL_ID  (APPR_SELL_ID),
    .TX_BUSY       (TX_BUSY),
    .TX_DATA       (TX_DATA),
    .TX_START      (TX_START),
    .FIFO_FULL     (FIFO_FULL),
    .FRAME_ACTIVE  (FRAME_ACTIVE),
    .DROP_COUNT    (DROP_COUNT)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // UART model: busy for 10 cycles after each accepted start.
  always @(posedge clk) begin
    if (uart_en && (TX_START === 1'b1)) busy_cnt <= 10;
    else if (busy_cnt != 0)             busy_cnt <= busy_cnt - 1;
  end
  assign TX_BUSY = busy_force | (busy_cnt != 0);

  // Record every start; flag back-to-back starts and TX_DATA changes between starts.
  always @(negedge clk) begin
    if (TX_START === 1'b1) begin
      starts.push_back(start_t'{cyc, TX_DATA});
      if (prev_start) b2b_err++;
      last_data = TX_DATA;
    end else if (TX_DATA !== last_data) begin
      stable_err++;
    end
    prev_start = (TX_START === 1'b1);
    if (RESET === 1'b0) begin
      last_data  = 8'h00;
      prev_start = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input vec_t v, input int i);
    case (i)
      0:       return 8'hA5;
      1:       return v.price;
      2:       return v.qty;
      3:       return v.buy;
      4:       return v.sell;
      5:       return v.ck;
      default: return 8'h00;
    endcase
  endfunction

  task automatic approve(input vec_t v);
    TRADE_APPROVED = 1'b1;
    APPR_PRICE     = v.price;
    APPR_QTY       = v.qty;
    APPR_BUY_ID    = v.buy;
    APPR_SELL_ID   = v.sell;
    app_cyc        = cyc;
    step();
    TRADE_APPROVED = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " TX_DATA"},      32'(TX_DATA),      32'h00);
    check({tag, " TX_START"},     32'(TX_START),     32'h0);
    check({tag, " FIFO_FULL"},    32'(FIFO_FULL),    32'h0);
    check({tag, " FRAME_ACTIVE"}, 32'(FRAME_ACTIVE), 32'h0);
    check({tag, " DROP_COUNT"},   32'(DROP_COUNT),   32'h00);
  endtask

  // Wait for one full frame of starts, then check bytes, first-start cycle and spacing.
  task automatic expect_frame(input string tag, input vec_t v, input int first_cyc,
                              input int gap, output int last_cyc);
    int     budget;
    int     prev;
    start_t s;
    budget   = 0;
    prev     = 0;
    last_cyc = 0;
    while (starts.size() < NB && budget < 3000) begin
      step();
      budget++;
    end
    if (starts.size() < NB) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: got %0d starts, required %0d", tag, starts.size(), NB);
      return;
    end
    for (int i = 0; i < NB; i++) begin
      s = starts.pop_front();
      check($sformatf("%s byte%0d data", tag, i), 32'(s.data), 32'(exp_byte(v, i)));
      if (i == 0 && first_cyc >= 0)
        check($sformatf("%s SOF cycle", tag), 32'(s.cyc), 32'(first_cyc));
      if (i > 0 && gap > 0)
        check($sformatf("%s byte%0d spacing", tag, i), 32'(s.cyc - prev), 32'(gap));
      prev = s.cyc;
    end
    last_cyc = prev;
  endtask

  initial begin
    int last;
    int t0;
    int budget;

    vecs[0] = '{8'h64, 8'h0A, 8'h03, 8'h07, 8'h6A};
    vecs[1] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};
    vecs[2] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    vecs[3] = '{8'hA5, 8'h5A, 8'h01, 8'h80, 8'h7E};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    RESET          = 1'b0;
    TRADE_APPROVED = 1'b0;
    APPR_PRICE     = 8'h00;
    APPR_QTY       = 8'h00;
    APPR_BUY_ID    = 8'h00;
    APPR_SELL_ID   = 8'h00;
    step();
    step();
    @(negedge clk);
    check_reset("reset");
    step();
    RESET = 1'b1;
    step();

    // Single trades, UART never busy: SOF at n+3, then 3 cycles per byte.
    for (int i = 0; i < 5; i++) begin
      approve(vecs[i]);
      t0 = app_cyc;
      step();
      step();
      @(negedge clk);
      check($sformatf("vec%0d TX_START at n+3", i), 32'(TX_START), 32'h1);
      check($sformatf("vec%0d TX_DATA at n+3", i), 32'(TX_DATA), 32'hA5);
      check($sformatf("vec%0d FRAME_ACTIVE", i), 32'(FRAME_ACTIVE), 32'h1);
      expect_frame($sformatf("vec%0d", i), vecs[i], t0 + 3, 3, last);
      repeat (3) step();
      @(negedge clk);
      check($sformatf("vec%0d FRAME_ACTIVE end", i), 32'(FRAME_ACTIVE), 32'h0);
    end

    // UART busy 10 cycles after each start: next start one cycle after busy falls.
    uart_en = 1'b1;
    approve(vecs[2]);
    expect_frame("uart", vecs[2], app_cyc + 3, 12, last);
    repeat (15) step();
    @(negedge clk);
    check("uart FRAME_ACTIVE end", 32'(FRAME_ACTIVE), 32'h0);
    step();
    uart_en = 1'b0;

    // Approval coincident with LOAD of the previous entry.
    approve(vecs[3]);
    t0 = app_cyc;
    step();
    approve(vecs[4]);
    expect_frame("coinc A", vecs[3], t0 + 3, 3, last);
    expect_frame("coinc B", vecs[4], last + 5, 3, last);
    repeat (5) step();
    @(negedge clk);
    check("coinc DROP_COUNT", 32'(DROP_COUNT), 32'h0);
    check("coinc FIFO_FULL", 32'(FIFO_FULL), 32'h0);
    step();

    // Six back-to-back approvals while UART is stuck busy: one in frame, four queued, one dropped.
    busy_force = 1'b1;
    for (int i = 0; i < 6; i++) begin
      approve(vecs[i % 5]);
      if (i == 0) t0 = app_cyc;
    end
    step();
    step();
    @(negedge clk);
    check("ovf FIFO_FULL", 32'(FIFO_FULL), 32'h1);
    check("ovf DROP_COUNT", 32'(DROP_COUNT), 32'h1);
    check("ovf starts while busy", 32'(starts.size()), 32'h1);
    check("ovf FRAME_ACTIVE", 32'(FRAME_ACTIVE), 32'h1);
    step();
    busy_force = 1'b0;
    expect_frame("ovf f0", vecs[0], t0 + 3, 0, last);
    for (int i = 1; i < 5; i++)
      expect_frame($sformatf("ovf f%0d", i), vecs[i], last + 5, 3, last);
    repeat (30) step();
    @(negedge clk);
    check("ovf no sixth frame", 32'(starts.size()), 32'h0);
    check("ovf FIFO_FULL drained", 32'(FIFO_FULL), 32'h0);
    check("ovf DROP_COUNT held", 32'(DROP_COUNT), 32'h1);
    step();

    // 300 approvals with UART busy: 295 more drops saturate the counter at 255.
    busy_force = 1'b1;
    for (int i = 0; i < 300; i++) approve(vecs[1]);
    step();
    @(negedge clk);
    check("sat DROP_COUNT", 32'(DROP_COUNT), 32'hFF);
    check("sat FIFO_FULL", 32'(FIFO_FULL), 32'h1);
    step();
    RESET = 1'b0;
    step();
    RESET      = 1'b1;
    busy_force = 1'b0;
    @(negedge clk);
    check_reset("sat reset");
    step();
    starts.delete();

    // Reset while byte 2 of a frame is in flight with two entries queued.
    approve(vecs[0]);
    approve(vecs[1]);
    approve(vecs[2]);
    budget = 0;
    while (starts.size() < 3 && budget < 100) begin
      step();
      budget++;
    end
    check("midrst reached byte2", 32'(starts.size()), 32'h3);
    RESET = 1'b0;
    step();
    RESET = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    repeat (40) step();
    check("midrst no start after reset", 32'(starts.size()), 32'h3);
    starts.delete();
    approve(vecs[3]);
    expect_frame("midrst new", vecs[3], app_cyc + 3, 3, last);
    repeat (30) step();
    check("midrst queue flushed", 32'(starts.size()), 32'h0);

    check("no back-to-back TX_START", 32'(b2b_err), 32'h0);
    check("TX_DATA held between starts", 32'(stable_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trade_report_framer.md
# trade_report_framer

Downstream stage of `risk_management`: captures each approved trade (price, quantity, buy ID, sell ID), queues it in a small FIFO and serialises it as a framed byte stream into the UART transmitter. Frames are emitted one byte at a time through a start/busy handshake, so bursts of approvals never stall the risk stage. Overflowing trades are dropped and counted.

## Interface
Parameters:
- `DEPTH`, 4, FIFO entries (power of 2, ≥2); each entry 32 bits {price, qty, buy_id, sell_id}.
- `SOF`, 8'hA5, start-of-frame byte.

Ports:
- `CLK` in 1: sole clock, rising edge.
- `RESET` in 1: synchronous, active-low; sampled on `CLK` rising edge.
- `TRADE_APPROVED` in 1: single-cycle pulse; `APPR_*` valid in same cycle.
- `APPR_PRICE` in 8: approved trade price.
- `APPR_QTY` in 8: approved quantity.
- `APPR_BUY_ID` in 8: buyer ID.
- `APPR_SELL_ID` in 8: seller ID.
- `TX_BUSY` in 1: UART transmitter busy; high while a byte is shifting.
- `TX_DATA` out 8: byte to transmit; valid when `TX_START`=1, held until next `TX_START`.
- `TX_START` out 1: single-cycle request to transmit `TX_DATA`.
- `FIFO_FULL` out 1: FIFO holds `DEPTH` entries.
- `FRAME_ACTIVE` out 1: high from LOAD until last byte's WAIT exits.
- `DROP_COUNT` out 8: trades dropped on full FIFO, saturates at 255.

## Operation
- Push: `TRADE_APPROVED`=1 and FIFO not full → entry written at write pointer, count+1. Full → entry discarded, `DROP_COUNT`+1 (saturating). Fullness is evaluated on the pre-edge count; a pop in the same cycle does not free a slot for that push.
- Pointers wrap modulo `DEPTH`; separate count register (0..`DEPTH`) decides full/empty.
- Frame bytes, in order: `SOF`, price, qty, buy_id, sell_id, [checksum]. Checksum = price ^ qty ^ buy_id ^ sell_id (`SOF` excluded).
- FSM states:
  - IDLE: count>0 → LOAD.
  - LOAD: pop head into frame register, byte index←0, `FRAME_ACTIVE`←1 → SEND.
  - SEND: `TX_START`=1, `TX_DATA`=byte[index] → HOLD.
  - HOLD: one cycle, `TX_BUSY` ignored (UART latch cycle) → WAIT.
  - WAIT: `TX_BUSY`=0 → if index is last: IDLE, `FRAME_ACTIVE`←0; else index+1 → SEND.
- IDLE to LOAD re-checks count, so back-to-back frames incur one idle cycle.
- Push concurrent with LOAD pop: both occur; count unchanged.
- Reset (`RESET`=0) at any point, including mid-frame: FSM→IDLE, pointers/count cleared, queued trades discarded, no further `TX_START`. A byte already handed to the UART is not recalled.

## Timing
- Reset values: `TX_DATA`=8'h00, `TX_START`=0, `FIFO_FULL`=0, `FRAME_ACTIVE`=0, `DROP_COUNT`=0.
- `TRADE_APPROVED` in cycle n with empty FIFO and FSM idle: IDLE sees entry at n+1, LOAD at n+2, first `TX_START` (SOF) at n+3.
- Per byte: SEND(1) + HOLD(1) + WAIT (≥1, until `TX_BUSY` low). Minimum 3 cycles/byte when `TX_BUSY` never asserts.
- `TX_START` is never high in two consecutive cycles.
- `FIFO_FULL` and `DROP_COUNT` update on the edge after the causing push/drop.

## Configuration
- `TRADE_REPORT_CHECKSUM_EN` defined: 6-byte frame, checksum byte sent last.
- Undefined: 5-byte frame ending at sell_id; no checksum logic synthesised. All other behaviour identical.

## Test plan
- Single trade price=0x64 qty=0x0A buy=0x03 sell=0x07, `TX_BUSY` tied 0 → `TX_START` at n+3, bytes A5 64 0A 03 07 6A (checksum on) or A5 64 0A 03 07 (off), 3 cycles apart.
- UART model raising `TX_BUSY` for 10 cycles after each start → next `TX_START` exactly 1 cycle after `TX_BUSY` falls; `TX_DATA` stable throughout.
- 6 approvals on consecutive cycles, `DEPTH`=4, `TX_BUSY` held 1 → 1 popped into frame, 4 queued, `FIFO_FULL`=1, `DROP_COUNT`=1; release busy → 5 complete frames in arrival order.
- 300 approvals while `TX_BUSY` held 1 → `DROP_COUNT` saturates at 255, no wrap.
- `RESET`=0 for one cycle during byte 2 of a frame with 2 entries queued → all outputs at reset values next cycle, no `TX_START` afterwards until a new approval.
- Approval coincident with LOAD of previous entry → no drop, count unchanged, both frames emitted intact.
